// File: rtl/mem_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_stage_pkg : shared encodings, bus widths and field offsets for MEM stage
// Revision      : 1.0
// ============================================================================
package mem_stage_pkg;

   localparam int WB_ZIP_W  = 103;
   localparam int EXC_ZIP_W = 97;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_B    = 3'd1;
   localparam logic [2:0] LD_H    = 3'd2;
   localparam logic [2:0] LD_W    = 3'd3;
   localparam logic [2:0] LD_BU   = 3'd4;
   localparam logic [2:0] LD_HU   = 3'd5;

   // Bit positions inside the 97-bit exception bus
   localparam int EXC_ESUBCODE_LSB   = 0;
   localparam int EXC_ECODE_LSB      = 9;
   localparam int EXC_SYSCALL_BIT    = 15;
   localparam int EXC_ERTN_BIT       = 16;
   localparam int EXC_CSR_NUM_LSB    = 17;
   localparam int EXC_CSR_WVALUE_LSB = 31;
   localparam int EXC_CSR_WMASK_LSB  = 63;
   localparam int EXC_CSR_WE_BIT     = 95;
   localparam int EXC_CSR_RE_BIT     = 96;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_READY  = 2'd2,
      ST_CANCEL = 2'd3
   } state_e;

   function automatic logic [WB_ZIP_W-1:0] pack_wb_zip(
      input logic [31:0] pc,
      input logic [31:0] ir,
      input logic        gr_we,
      input logic [4:0]  waddr,
      input logic [31:0] wdata
   );
      return {1'b1, pc, ir, gr_we, waddr, wdata};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_stage_if : EX->MEM, SRAM response, WB-side bus and forwarding signals
// Revision     : 1.0
// ============================================================================
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                  ex_valid;
   logic                  mem_allowin;
   logic [31:0]           ex_pc;
   logic [31:0]           ex_IR;
   logic                  ex_gr_we;
   logic [4:0]            ex_dest;
   logic [31:0]           ex_alu_result;
   logic                  ex_mem_req;
   logic [2:0]            ex_ld_op;
   logic [EXC_ZIP_W-1:0]  ex_except_zip;
   logic                  data_sram_data_ok;
   logic [31:0]           data_sram_rdata;
   logic                  WB_allowin;
   logic                  wb_ex;
   logic                  ertn_flush;
   logic [WB_ZIP_W-1:0]   MEM_to_WB_zip;
   logic [EXC_ZIP_W-1:0]  MEM_except_zip;
   logic                  mem_fwd_valid;
   logic [4:0]            mem_fwd_waddr;
   logic [31:0]           mem_fwd_wdata;
   logic                  mem_ld_pending;

   modport master (
      output ex_valid, ex_pc, ex_IR, ex_gr_we, ex_dest, ex_alu_result,
             ex_mem_req, ex_ld_op, ex_except_zip, data_sram_data_ok,
             data_sram_rdata, WB_allowin, wb_ex, ertn_flush,
      input  mem_allowin, MEM_to_WB_zip, MEM_except_zip, mem_fwd_valid,
             mem_fwd_waddr, mem_fwd_wdata, mem_ld_pending
   );

   modport slave (
      input  ex_valid, ex_pc, ex_IR, ex_gr_we, ex_dest, ex_alu_result,
             ex_mem_req, ex_ld_op, ex_except_zip, data_sram_data_ok,
             data_sram_rdata, WB_allowin, wb_ex, ertn_flush,
      output mem_allowin, MEM_to_WB_zip, MEM_except_zip, mem_fwd_valid,
             mem_fwd_waddr, mem_fwd_wdata, mem_ld_pending
   );

endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_load_align : selects and extends load data by ld_op and address offset
// Revision       : 1.0
// ============================================================================
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  ld_op,
   input  logic [31:0] alu_result,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [1:0]  addr;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign addr     = alu_result[1:0];
   assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   always_comb begin
      result = alu_result;
      case (ld_op)
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_W:    result = rdata;
         LD_BU:   result = {24'd0, byte_sel};
         LD_HU:   result = {16'd0, half_sel};
         default: result = alu_result;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_stage : LA32R MEM stage - holds EX/MEM state, waits on data SRAM,
//             aligns load data and drives the registered WB buses
// Revision  : 1.0
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.slave bus
);

   state_e                state_q,    state_d;
   logic [31:0]           pc_q,       pc_d;
   logic [31:0]           ir_q,       ir_d;
   logic                  gr_we_q,    gr_we_d;
   logic [4:0]            dest_q,     dest_d;
   logic [31:0]           alu_q,      alu_d;
   logic [2:0]            ld_op_q,    ld_op_d;
   logic [EXC_ZIP_W-1:0]  exc_q,      exc_d;
   logic [31:0]           rdata_q,    rdata_d;
   logic [WB_ZIP_W-1:0]   wb_zip_q,   wb_zip_d;
   logic [EXC_ZIP_W-1:0]  wb_exc_q,   wb_exc_d;

   logic        flush;
   logic        ready_go;
   logic        allowin;
   logic        accept;
   logic        wb_valid;
   logic [31:0] wdata;

   assign flush    = bus.wb_ex | bus.ertn_flush;
   assign ready_go = (state_q == ST_READY);
   // CANCEL is neither EMPTY nor READY, so it blocks EX without an extra term
   assign allowin  = ((state_q == ST_EMPTY) | (ready_go & bus.WB_allowin)) & ~flush;
   assign accept   = bus.ex_valid & allowin;
   assign wb_valid = ready_go & ~flush;

   mem_load_align u_align (
      .ld_op      (ld_op_q),
      .alu_result (alu_q),
      .rdata      (rdata_q),
      .result     (wdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) state_d = bus.ex_mem_req ? ST_WAIT : ST_READY;
         end
         ST_WAIT: begin
            if (flush)                      state_d = bus.data_sram_data_ok ? ST_EMPTY : ST_CANCEL;
            else if (bus.data_sram_data_ok) state_d = ST_READY;
         end
         ST_READY: begin
            if (accept)                         state_d = bus.ex_mem_req ? ST_WAIT : ST_READY;
            else if (flush | bus.WB_allowin)    state_d = ST_EMPTY;
         end
         ST_CANCEL: begin
            if (bus.data_sram_data_ok) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      gr_we_d = gr_we_q;
      dest_d  = dest_q;
      alu_d   = alu_q;
      ld_op_d = ld_op_q;
      exc_d   = exc_q;
      if (accept) begin
         pc_d    = bus.ex_pc;
         ir_d    = bus.ex_IR;
         gr_we_d = bus.ex_gr_we;
         dest_d  = bus.ex_dest;
         alu_d   = bus.ex_alu_result;
         ld_op_d = bus.ex_ld_op;
         exc_d   = bus.ex_except_zip;
      end
      rdata_d = (state_q == ST_WAIT && bus.data_sram_data_ok) ? bus.data_sram_rdata : rdata_q;
   end

   // WB bus reloads whenever WB can take it; a bubble loads all-zero
   always_comb begin
      wb_zip_d = wb_zip_q;
      wb_exc_d = wb_exc_q;
      if (bus.WB_allowin) begin
         wb_zip_d = wb_valid ? pack_wb_zip(pc_q, ir_q, gr_we_q, dest_q, wdata) : '0;
         wb_exc_d = wb_valid ? exc_q : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         pc_q     <= '0;
         ir_q     <= '0;
         gr_we_q  <= 1'b0;
         dest_q   <= '0;
         alu_q    <= '0;
         ld_op_q  <= LD_NONE;
         exc_q    <= '0;
         rdata_q  <= '0;
         wb_zip_q <= '0;
         wb_exc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         gr_we_q  <= gr_we_d;
         dest_q   <= dest_d;
         alu_q    <= alu_d;
         ld_op_q  <= ld_op_d;
         exc_q    <= exc_d;
         rdata_q  <= rdata_d;
         wb_zip_q <= wb_zip_d;
         wb_exc_q <= wb_exc_d;
      end
   end

   assign bus.mem_allowin    = allowin;
   assign bus.MEM_to_WB_zip  = wb_zip_q;
   assign bus.MEM_except_zip = wb_exc_q;
   assign bus.mem_fwd_valid  = ((state_q == ST_WAIT) | (state_q == ST_READY)) & gr_we_q;
   assign bus.mem_fwd_waddr  = dest_q;
   assign bus.mem_fwd_wdata  = wdata;
   assign bus.mem_ld_pending = (state_q == ST_WAIT) & (ld_op_q != LD_NONE);

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the LA32R five-stage CPU, directly upstream of WB.
- Holds the EX/MEM pipeline state and waits for the data-SRAM response on loads and stores. Aligns and extends load data.
- Drives the registered MEM_to_WB_zip and MEM_except_zip buses that WB decodes combinationally. Cancels in-flight work on WB exception or ertn flush.

Parameters:
- none. Widths are fixed by the 32-bit datapath and the WB bus layouts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  EX presents an instruction
- mem_allowin  out  1  MEM can accept from EX this cycle
- ex_pc  in  32  instruction PC
- ex_IR  in  32  instruction word
- ex_gr_we  in  1  writes the GPR file
- ex_dest  in  5  destination register
- ex_alu_result  in  32  ALU result, or effective address for memory ops
- ex_mem_req  in  1  data-SRAM request was issued in EX (load or store)
- ex_ld_op  in  3  0 none, 1 LD_B, 2 LD_H, 3 LD_W, 4 LD_BU, 5 LD_HU
- ex_except_zip  in  97  {csr_re, csr_we, csr_wmask[31:0], csr_wvalue[31:0], csr_num[13:0], ertn_flush, inst_syscall, ecode[5:0], esubcode[8:0]}
- data_sram_data_ok  in  1  response strobe for the oldest outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok
- WB_allowin  in  1  WB can accept
- wb_ex  in  1  exception flush from WB
- ertn_flush  in  1  ertn flush from WB
- MEM_to_WB_zip  out  103  registered {valid, pc, IR, gr_we, rf_waddr[4:0], rf_wdata[31:0]}
- MEM_except_zip  out  97  registered copy of ex_except_zip for the instruction in WB
- mem_fwd_valid  out  1  MEM holds a valid GPR-writing instruction
- mem_fwd_waddr  out  5  its destination register
- mem_fwd_wdata  out  32  its result; meaningful only when mem_ld_pending=0
- mem_ld_pending  out  1  load data not yet available; the hazard unit must stall

Behaviour:
- Reset: state EMPTY, both zips all-zero, fwd outputs 0, mem_allowin=1.
- flush = wb_ex | ertn_flush.
- States:
  - EMPTY: no instruction held.
  - WAIT: holds an instruction with a request outstanding.
  - READY: holds an instruction whose result is complete.
  - CANCEL: the held instruction was flushed; its response is still owed.
- ready_go = (state==READY).
- mem_allowin = (state==EMPTY) | (ready_go & WB_allowin); forced 0 in CANCEL or when flush=1.
- Accept: when ex_valid & mem_allowin & ~flush, latch all ex_* fields. Next state is WAIT if ex_mem_req, else READY.
- WAIT -> READY on data_ok; capture rdata into an internal buffer the same cycle.
- READY -> EMPTY on WB_allowin, unless a new instruction is accepted in the same cycle.
- Flush:
  - WAIT without data_ok -> CANCEL. WAIT with data_ok -> EMPTY.
  - READY -> EMPTY.
  - CANCEL -> EMPTY on data_ok; that data is discarded.
- Output register loads on every cycle with WB_allowin=1, and holds otherwise:
  - valid bit = ready_go & ~flush.
  - Payload fields and MEM_except_zip come from the held instruction.
  - If valid would be 0, the whole MEM_to_WB_zip and MEM_except_zip load zero.
- rf_wdata:
  - ld_op==0: rf_wdata = alu_result.
  - Otherwise, with a = alu_result[1:0]:
    - byte = buffered_rdata[8a+7 : 8a]
    - half = a[1] ? rdata[31:16] : rdata[15:0]
    - LD_B / LD_H sign-extend; LD_BU / LD_HU zero-extend; LD_W takes the full word.
  - Misaligned addresses are already excepted upstream; MEM applies no check.
- Forwarding:
  - mem_fwd_valid = (state in WAIT/READY) & gr_we.
  - mem_ld_pending = (state==WAIT) & (ld_op!=0).
  - mem_fwd_wdata follows the same extension logic as rf_wdata.
- Boundaries:
  - data_ok in EMPTY or READY is a protocol error; ignore it (bench assertion).
  - Async reset in WAIT or CANCEL returns to EMPTY immediately. The SRAM side is reset by the same rst.
  - Instructions with inst_syscall=1 arrive with ex_mem_req=0 and pass straight through READY.

Decomposition:
- Shared package holds:
  - ld_op encodings
  - state encoding
  - bus widths: 103 for MEM_to_WB, 97 for except
  - except-zip field offsets
- One sub-module, mem_load_align: combinational (ld_op, addr[1:0], rdata) -> 32-bit result. It is instanced twice, for rf_wdata and fwd_wdata, or shared.

Test Plan:
- LD_B, addr 0x1003, rdata 0x80FF_1234, data_ok 1 cycle after accept -> WB zip valid next cycle, rf_wdata 0xFFFF_FF80.
- LD_HU, addr offset 2, same rdata -> rf_wdata 0x0000_80FF. LD_H -> 0xFFFF_80FF.
- Load with data_ok delayed 3 cycles:
  - mem_allowin=0 and mem_ld_pending=1 for those cycles.
  - WB valid appears exactly 1 cycle after data_ok.
  - Back-to-back ALU op accepted in the data_ok+1 cycle.
- wb_ex pulse while in WAIT:
  - state CANCEL, mem_allowin=0.
  - Next data_ok (rdata 0xDEAD_BEEF) dropped, no WB valid.
  - EMPTY the following cycle.
- syscall with ex_except_zip inst_syscall=1, ecode 0x0B, no mem_req -> MEM_except_zip carries the same 97 bits next cycle; WB valid=1.
- Assert rst mid-WAIT -> zips zero the same edge, mem_allowin=1. A stray later data_ok has no effect.
